// File: rtl/sine_ctrl_if.sv
// Tuning-word handshake between the control registers and the sine sequencer.
interface sine_ctrl_if #(
  parameter int PHASE_W = 32
);
  logic [PHASE_W-1:0] ftw_data;
  logic               ftw_valid;
  logic               ftw_ready;

  modport master (output ftw_data, output ftw_valid, input ftw_ready);
  modport slave  (input ftw_data, input ftw_valid, output ftw_ready);
endinterface

// File: rtl/sine_ctrl.sv
// Phase-accumulator sequencer for the sine ROM feeding the sigma-delta DAC:
// glitch-free FTW updates at phase wrap, amplitude scaling, clean stop at midscale.
//
// state | meaning
// IDLE  | stopped, phase 0, no ticks; accepted FTW goes straight to ftw_active
// RUN   | generating samples at the programmed tick rate
// DRAIN | stop requested; keep ticking until the phase wraps
module sine_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int BITLEN  = 16,
  parameter int PHASE_W = 32,
  parameter int DIV_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  sine_ctrl_if.slave        ftw,
  input  logic [DIV_W-1:0]  div,
  input  logic [8:0]        amp,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [BITLEN-1:0] rom_data,
  output logic [BITLEN-1:0] sample,
  output logic              sample_valid,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [BITLEN-1:0] MID = {1'b1, {(BITLEN-1){1'b0}}};

  state_t              state;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  ftw_active;
  logic [PHASE_W-1:0]  ftw_pend;
  logic                pend_full;
  logic [DIV_W-1:0]    div_cnt;
  logic                v1, v2, f1, f2;
  logic                tick, carry, wrap, stop, xfer;
  logic [PHASE_W:0]    sum;
  logic [8:0]          amp_c;
  logic signed [BITLEN+9:0] d, gain;

  always_comb begin
    tick  = (state != IDLE) && (div_cnt == '0);
    sum   = {1'b0, phase} + {1'b0, ftw_active};
    carry = sum[PHASE_W];
    wrap  = tick && carry;
    // A zero tuning word never wraps, so drain ends on the next tick instead.
    stop  = tick && (state == DRAIN) && !run && (carry || (ftw_active == '0));
    xfer  = ftw.ftw_valid && ftw.ftw_ready;
    amp_c = (amp > 9'd256) ? 9'd256 : amp;
    d     = $signed({10'b0, rom_data}) - $signed({10'b0, MID});
    gain  = $signed({{(BITLEN+1){1'b0}}, amp_c});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= '0;
      rom_addr      <= '0;
      ftw_active    <= '0;
      ftw_pend      <= '0;
      pend_full     <= 1'b0;
      ftw.ftw_ready <= 1'b1;
      sample        <= MID;
      sample_valid  <= 1'b0;
      busy          <= 1'b0;
      div_cnt       <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      f1            <= 1'b0;
      f2            <= 1'b0;
    end else begin
      // Pipeline: tick -> rom_addr -> rom_data -> sample (3 cycles).
      v1           <= 1'b0;
      f1           <= 1'b0;
      v2           <= v1;
      f2           <= f1;
      sample_valid <= v2;
      if (v2)
        sample <= f2 ? MID : MID + BITLEN'((d * gain) >>> 8);

      if (state == IDLE)
        div_cnt <= '0;
      else if (tick)
        div_cnt <= div;
      else
        div_cnt <= div_cnt - 1'b1;

      if (tick) begin
        v1 <= 1'b1;
        if (stop) begin
          phase    <= '0;
          rom_addr <= '0;
          f1       <= 1'b1;
        end else begin
          phase    <= sum[PHASE_W-1:0];
          rom_addr <= sum[PHASE_W-1 -: ADDR_W];
        end
      end

      case (state)
        IDLE: if (run) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (!run) state <= DRAIN;
        DRAIN: begin
          if (run) begin
            state <= RUN;
          end else if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (state == IDLE) begin
        if (xfer) begin
          ftw_active <= ftw.ftw_data;
        end else if (pend_full) begin
          ftw_active    <= ftw_pend;
          pend_full     <= 1'b0;
          ftw.ftw_ready <= 1'b1;
        end
      end else begin
        if (wrap && pend_full)
          ftw_active <= ftw_pend;
        if (xfer) begin
          ftw_pend      <= ftw.ftw_data;
          pend_full     <= 1'b1;
          ftw.ftw_ready <= 1'b0;
        end else if (wrap) begin
          pend_full     <= 1'b0;
          ftw.ftw_ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sine_ctrl.sv
// Directed bench for sine_ctrl: ramp ROM model with an override for scaling vectors.
module tb_sine_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] div = '0;
  logic [8:0]  amp = 9'd256;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        rom_ovr_en = 1'b0;
  logic [15:0] rom_ovr = '0;

  int n_chk  = 0;
  int n_fail = 0;

  sine_ctrl_if #(.PHASE_W(32)) ftw_if ();

  sine_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .ftw          (ftw_if),
    .div          (div),
    .amp          (amp),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= rom_ovr_en ? rom_ovr : {6'b0, rom_addr};

  typedef struct {
    logic [15:0] rom;
    logic [8:0]  amp;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic send_ftw(input logic [31:0] w);
    ftw_if.ftw_data  = w;
    ftw_if.ftw_valid = 1'b1;
    step();
    ftw_if.ftw_valid = 1'b0;
  endtask

  initial begin
    int steps, pulses, step_err, rdy_err;
    logic [9:0] a0, prev;
    bit found;

    vecs[0]  = '{16'hFFFF, 9'd256, 16'hFFFF};
    vecs[1]  = '{16'hFFFF, 9'd128, 16'hBFFF};
    vecs[2]  = '{16'hFFFF, 9'd300, 16'hFFFF};
    vecs[3]  = '{16'h0000, 9'd256, 16'h0000};
    vecs[4]  = '{16'h0000, 9'd128, 16'h4000};
    vecs[5]  = '{16'h0000, 9'd0,   16'h8000};
    vecs[6]  = '{16'h8000, 9'd200, 16'h8000};
    vecs[7]  = '{16'h0001, 9'd128, 16'h4000};
    vecs[8]  = '{16'hC000, 9'd64,  16'h9000};
    vecs[9]  = '{16'h7FFF, 9'd511, 16'h7FFF};
    vecs[10] = '{16'h0003, 9'd1,   16'h7F80};
    vecs[11] = '{16'hFFFF, 9'd1,   16'h807F};
    vecs[12] = '{16'hFFFF, 9'd257, 16'hFFFF};

    ftw_if.ftw_data  = '0;
    ftw_if.ftw_valid = 1'b0;

    // Reset state
    step(2);
    rst = 1'b0;
    chk("rst_addr", rom_addr, 10'd0);
    chk("rst_sample", sample, 16'h8000);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ftw_if.ftw_ready, 1'b1);

    // Ramp at div=0, ftw one address per tick, loaded while idle
    send_ftw(32'h0040_0000);
    chk("idle_ready", ftw_if.ftw_ready, 1'b1);
    run = 1'b1;
    step();
    chk("run_busy", busy, 1'b1);
    chk("run_addr0", rom_addr, 10'd0);
    step();
    chk("addr1", rom_addr, 10'd1);
    chk("valid_e1", sample_valid, 1'b0);
    step();
    chk("addr2", rom_addr, 10'd2);
    chk("valid_e2", sample_valid, 1'b0);
    step();
    chk("addr3", rom_addr, 10'd3);
    chk("first_valid", sample_valid, 1'b1);
    chk("first_sample", sample, 16'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ramp_valid", sample_valid, 1'b1);
      chk("ramp_sample", sample, {6'b0, rom_addr - 10'd2});
    end

    // Drain from address 500 until wrap
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (rom_addr == 10'd500) found = 1; else step();
    end
    if (!found) timeout("reach_500");
    run = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (!busy) found = 1;
    end
    if (!found) timeout("drain_idle");
    chk("drain_addr0", rom_addr, 10'd0);
    chk("drain_pipe1022", sample, 16'd1022);
    step();
    chk("drain_pipe1023", sample, 16'd1023);
    step();
    chk("final_valid", sample_valid, 1'b1);
    chk("final_mid", sample, 16'h8000);
    step();
    chk("final_valid_off", sample_valid, 1'b0);
    chk("final_hold", sample, 16'h8000);
    chk("idle_addr", rom_addr, 10'd0);

    // div=3: one sample every 4 cycles
    div = 16'd3;
    run = 1'b1;
    step(8);
    a0 = rom_addr;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sample_valid) pulses++;
    end
    chk("div3_pulses", pulses, 10);
    chk("div3_addr_steps", rom_addr - a0, 10'd10);

    // FTW change mid-run applies only at wrap
    div = 16'd0;
    step(8);
    send_ftw(32'h0080_0000);
    chk("pend_ready_low", ftw_if.ftw_ready, 1'b0);
    prev = rom_addr;
    step_err = 0;
    rdy_err = 0;
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      step();
      if (rom_addr != prev) begin
        if (prev == 10'd1023 && rom_addr == 10'd0) found = 1;
        else if (rom_addr != prev + 10'd1) step_err++;
      end
      if (!found && ftw_if.ftw_ready) rdy_err++;
      prev = rom_addr;
    end
    if (!found) timeout("ftw_wrap");
    chk("old_step_errs", step_err, 0);
    chk("ready_held_low", rdy_err, 0);
    chk("ready_after_wrap", ftw_if.ftw_ready, 1'b1);
    step();
    chk("new_step_a", rom_addr, 10'd2);
    step();
    chk("new_step_b", rom_addr, 10'd4);

    // Reset mid-run with a pending word
    send_ftw(32'h0100_0000);
    chk("pend2_ready", ftw_if.ftw_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("mrst_addr", rom_addr, 10'd0);
    chk("mrst_sample", sample, 16'h8000);
    chk("mrst_valid", sample_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ready", ftw_if.ftw_ready, 1'b1);
    rst = 1'b0;
    step(8);
    chk("resume_addr", rom_addr, 10'd0);
    chk("resume_sample", sample, 16'h0000);
    chk("resume_valid", sample_valid, 1'b1);

    // Amplitude scaling vectors at a fixed address
    rom_ovr_en = 1'b1;
    foreach (vecs[k]) begin
      rom_ovr = vecs[k].rom;
      amp     = vecs[k].amp;
      step(4);
      chk($sformatf("scale[%0d]", k), sample, vecs[k].exp);
    end
    chk("scale_valid", sample_valid, 1'b1);

    // Stop with ftw_active=0: ends on next tick, midscale last
    run = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (!busy) found = 1;
    end
    if (!found) timeout("zero_ftw_stop");
    step(2);
    chk("zstop_valid", sample_valid, 1'b1);
    chk("zstop_mid", sample, 16'h8000);
    step();
    chk("zstop_valid_off", sample_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sine_ctrl.md
# sine_ctrl

Sequencer for the sine ROM that feeds the sigma-delta DAC. A phase accumulator produces the ROM address at a programmable sample rate. Frequency-tuning-word (FTW) updates are accepted through a valid/ready handshake and applied only at phase wrap, so the output stays glitch-free. The ROM output is amplitude-scaled, and the block stops cleanly at a phase wrap, leaving the DAC at midscale. It sits between the control registers and the sigma-delta modulator input.

## Interface
- ADDR_W, 10: ROM address width (1024 entries).
- BITLEN, 16: sample width, offset binary (midscale = 2^(BITLEN-1)).
- PHASE_W, 32: phase accumulator width; must be ≥ ADDR_W.
- DIV_W, 16: sample-period divider width.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = generate, 0 = request stop.
- ftw_data  in  PHASE_W  new tuning word.
- ftw_valid  in  1  ftw_data valid.
- ftw_ready  out  1  block can accept a tuning word.
- div  in  DIV_W  sample period minus 1 (a tick occurs every div+1 cycles).
- amp  in  9  amplitude; 256 = unity; values >256 are treated as 256.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_data  in  BITLEN  ROM word; valid exactly 1 cycle after rom_addr changes (synchronous ROM).
- sample  out  BITLEN  scaled sample to the modulator.
- sample_valid  out  1  one-cycle pulse per new sample.
- busy  out  1  high in RUN or DRAIN.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN when run=1.
  - RUN→DRAIN when run=0.
  - DRAIN→RUN when run=1.
  - DRAIN→IDLE on the tick whose accumulation carries out of the MSB (wrap). Also DRAIN→IDLE on the next tick if ftw_active=0.
- Registers: ftw_active (in use) and ftw_pend plus a pend_full flag (one-deep holding register).
  - ftw_ready = !pend_full.
  - Transfer occurs when ftw_valid && ftw_ready.
- FTW application:
  - In IDLE, the accepted word goes straight to ftw_active on the next cycle; pend_full stays 0.
  - In RUN/DRAIN, the accepted word goes to ftw_pend and pend_full=1. It is copied to ftw_active on the first tick that wraps; pend_full then clears.
  - Transfer and wrap in the same cycle: the old pending word is applied, then the new word is stored.
- Divider: down-counter.
  - On entering RUN from IDLE it is loaded with 0, so a tick occurs on the first RUN cycle.
  - On a tick it reloads with div. A div change takes effect at the next reload.
  - No ticks occur in IDLE.
- On tick:
  - phase <= phase + ftw_active, modulo 2^PHASE_W.
  - rom_addr <= new phase[PHASE_W-1 -: ADDR_W].
- Scaling:
  - d = rom_data − midscale, signed BITLEN+1.
  - p = d × min(amp,256).
  - sample = midscale + (p >>> 8), arithmetic shift, truncating toward −∞.
  - The result cannot overflow because the gain is ≤ 1.
- On DRAIN→IDLE:
  - phase <= 0 and rom_addr <= 0.
  - Samples already in the pipeline still emerge.
  - After them, sample is forced to midscale with one final sample_valid pulse.
- Reset values:
  - state IDLE; phase 0; rom_addr 0; ftw_active 0; pend_full 0.
  - ftw_ready 1; sample midscale; sample_valid 0; busy 0; divider 0.
- Reset asserted mid-operation: all of the above values apply on the next edge, and any pending FTW is discarded.

## Timing
- Tick at cycle t:
  - rom_addr updates at t+1.
  - rom_data is valid at t+2.
  - sample and sample_valid are registered at t+3.
  - Fixed latency: 3 cycles.
- sample holds its value between pulses.
- sample_valid is high for exactly 1 cycle per tick.
- busy changes the cycle after the state transition edge.
- Minimum tick spacing is 1 cycle (div=0); the pipeline sustains a sample every cycle.
- ftw_ready deasserts the cycle after a RUN-state transfer and reasserts the cycle after the applying wrap.

## Test plan
- Reset, then run=1 with ftw=2^22 (1 address step per tick), div=0, and a ROM model holding i at address i → rom_addr goes 1,2,3…; the first sample_valid occurs 3 cycles after the first RUN cycle; sample equals the ROM word at amp=256.
- div=3, ftw=2^22 → exactly one sample_valid every 4 cycles; rom_addr steps once per 4 cycles.
- While in RUN, send ftw=2^23 mid-period → ftw_ready drops and the address step stays 1 until rom_addr wraps 1023→0; steps then become 2 and ftw_ready returns to 1.
- amp=128 with rom_data=0xFFFF → sample=0xBFFF. amp=300 with the same data → sample=0xFFFF (clamped to unity).
- run=0 at rom_addr=500 with ftw=2^22 → ticks continue until the phase wraps; state goes IDLE, rom_addr=0, the final sample=0x8000, busy=0.
- Assert rst mid-RUN with a pending FTW → the next cycle shows all reset values; a new run=1 resumes from rom_addr=0 with ftw_active=0 (constant sample).
